// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use, ID-branch operand,
// and MDU busy stalls, taken-branch flush, memory-wait freeze, stall counter.

module hazard_match #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic          use_rs,
  input  logic          use_rt,
  input  logic [AW-1:0] x,
  output logic          hit
);
  // $0 is hard-wired zero, so a write to it never creates a dependency
  assign hit = (x != '0) && (((x == rs) && use_rs) || ((x == rt) && use_rt));
endmodule

module hazard_ctrl #(
  parameter int AW         = 5,
  parameter int MDU_CYCLES = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    if_id_rs,
  input  logic [AW-1:0]    if_id_rt,
  input  logic             if_id_use_rs,
  input  logic             if_id_use_rt,
  input  logic             if_id_branch,
  input  logic             if_id_mdu_use,
  input  logic             branch_taken,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_reg_write,
  input  logic [AW-1:0]    id_ex_dest,
  input  logic             id_ex_mdu_start,
  input  logic             ex_mem_mem_read,
  input  logic [AW-1:0]    ex_mem_dest,
  input  logic             ext_stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int NSRC = 2;
  localparam int MW   = $clog2(MDU_CYCLES + 1);
  localparam logic [MW-1:0]    MDU_LOAD = MW'(MDU_CYCLES);
  localparam logic [MW-1:0]    MDU_ONE  = MW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_bubble;
    logic if_id_flush;
  } ctl_t;

  // source 0 = destination in EX, source 1 = destination in MEM
  logic [NSRC-1:0][AW-1:0] dst;
  logic [NSRC-1:0]         hit;
  assign dst = {ex_mem_dest, id_ex_dest};

  genvar g;
  generate
    for (g = 0; g < NSRC; g++) begin : g_match
      hazard_match #(.AW(AW)) u_match (
        .rs     (if_id_rs),
        .rt     (if_id_rt),
        .use_rs (if_id_use_rs),
        .use_rt (if_id_use_rt),
        .x      (dst[g]),
        .hit    (hit[g])
      );
    end
  endgenerate

  logic [MW-1:0]    mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             load_use, br_haz, mdu_haz, hazard;
  ctl_t             ctl;

  assign mdu_busy = (mdu_cnt_q != '0);
  assign load_use = id_ex_mem_read && hit[0];
  // branches compare in ID, so even ALU results in EX are not yet forwardable
  assign br_haz   = if_id_branch && ((id_ex_reg_write && hit[0]) ||
                                     (ex_mem_mem_read && hit[1]));
  assign mdu_haz  = if_id_mdu_use && (mdu_busy || id_ex_mdu_start);
  assign hazard   = load_use || br_haz || mdu_haz;

  always_comb begin
    ctl = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_bubble: 1'b0,
            if_id_flush: if_id_branch && branch_taken};
    if (!rst_n)
      ctl = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_bubble: 1'b1, if_id_flush: 1'b0};
    else if (ext_stall)
      ctl = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_bubble: 1'b0, if_id_flush: 1'b0};
    else if (hazard)
      ctl = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_bubble: 1'b1, if_id_flush: 1'b0};
  end

  assign pc_write     = ctl.pc_write;
  assign if_id_write  = ctl.if_id_write;
  assign id_ex_bubble = ctl.id_ex_bubble;
  assign if_id_flush  = ctl.if_id_flush;
  assign stall_cycles = stall_q;

  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (id_ex_mdu_start)  mdu_cnt_d = MDU_LOAD;
    else if (mdu_busy)    mdu_cnt_d = mdu_cnt_q - MDU_ONE;
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_write && (stall_q != '1)) stall_d = stall_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_cnt_q <= '0;
      stall_q   <= '0;
    end else begin
      mdu_cnt_q <= mdu_cnt_d;
      stall_q   <= stall_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; driver queues expected outputs,
// a monitor on the falling edge pops and compares.

module tb_hazard_ctrl;
  localparam int AW = 5, MDU = 4, CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] rs, rt, id_ex_dest, ex_mem_dest;
  logic use_rs, use_rt, br, mdu_use, taken, mem_read, reg_write, mdu_start, exm_rd, ext;
  logic pc_write, if_id_write, id_ex_bubble, if_id_flush, mdu_busy;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_ctrl #(.AW(AW), .MDU_CYCLES(MDU), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs(rs), .if_id_rt(rt), .if_id_use_rs(use_rs), .if_id_use_rt(use_rt),
    .if_id_branch(br), .if_id_mdu_use(mdu_use), .branch_taken(taken),
    .id_ex_mem_read(mem_read), .id_ex_reg_write(reg_write), .id_ex_dest(id_ex_dest),
    .id_ex_mdu_start(mdu_start), .ex_mem_mem_read(exm_rd), .ex_mem_dest(ex_mem_dest),
    .ext_stall(ext),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic rst_n;
    logic [AW-1:0] rs, rt, dest, exm_dest;
    logic use_rs, use_rt, br, mdu_use, taken, mem_read, reg_write, mdu_start, exm_rd, ext;
  } in_t;

  typedef struct {
    logic [8:0] v;  // {pc_write, if_id_write, bubble, flush, busy, stall_cycles}
    string      name;
  } exp_t;

  exp_t sb[$];
  int   total = 0, passed = 0;

  function automatic in_t idle();
    in_t i;
    i = '{rst_n: 1'b1, rs: '0, rt: '0, dest: '0, exm_dest: '0, use_rs: 1'b0, use_rt: 1'b0,
          br: 1'b0, mdu_use: 1'b0, taken: 1'b0, mem_read: 1'b0, reg_write: 1'b0,
          mdu_start: 1'b0, exm_rd: 1'b0, ext: 1'b0};
    return i;
  endfunction

  task automatic drive(input in_t i, input string name, input logic pw, input logic iw,
                       input logic bub, input logic fl, input logic busy, input int sc);
    exp_t e;
    @(posedge clk); #1;
    rst_n = i.rst_n; rs = i.rs; rt = i.rt; use_rs = i.use_rs; use_rt = i.use_rt;
    br = i.br; mdu_use = i.mdu_use; taken = i.taken; mem_read = i.mem_read;
    reg_write = i.reg_write; id_ex_dest = i.dest; mdu_start = i.mdu_start;
    exm_rd = i.exm_rd; ex_mem_dest = i.exm_dest; ext = i.ext;
    e.v = {pw, iw, bub, fl, busy, CW'(sc)};
    e.name = name;
    sb.push_back(e);
  endtask

  // monitor: one expected entry per cycle, checked mid-cycle
  initial begin
    exp_t e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = {pc_write, if_id_write, id_ex_bubble, if_id_flush, mdu_busy, stall_cycles};
        total++;
        if (act !== e.v)
          $display("FAIL %s: got pw/iw/bub/fl/busy=%b sc=%0d, want %b sc=%0d",
                   e.name, act[8:4], act[3:0], e.v[8:4], e.v[3:0]);
        else
          passed++;
      end
    end
  end

  initial begin
    in_t v;
    v = idle(); v.rst_n = 1'b0;
    rst_n = 1'b0; rs = '0; rt = '0; use_rs = 0; use_rt = 0; br = 0; mdu_use = 0; taken = 0;
    mem_read = 0; reg_write = 0; id_ex_dest = '0; mdu_start = 0; exm_rd = 0;
    ex_mem_dest = '0; ext = 0;

    drive(v, "rst_state", 0, 0, 1, 0, 0, 0);
    v.ext = 1'b1;
    drive(v, "rst_over_ext", 0, 0, 1, 0, 0, 0);

    v = idle();
    drive(v, "first_after_rst", 1, 1, 0, 0, 0, 0);
    v = idle(); v.mem_read = 1; v.reg_write = 1; v.dest = 2; v.rs = 2; v.use_rs = 1;
    drive(v, "load_use_rs", 0, 0, 1, 0, 0, 0);
    v = idle(); v.exm_rd = 1; v.exm_dest = 2; v.rs = 2; v.use_rs = 1;
    drive(v, "load_in_mem_fwd", 1, 1, 0, 0, 0, 1);
    v = idle(); v.mem_read = 1; v.reg_write = 1; v.dest = 0; v.rs = 0; v.use_rs = 1;
    drive(v, "load_r0", 1, 1, 0, 0, 0, 1);
    v = idle(); v.mem_read = 1; v.dest = 2; v.rs = 2; v.rt = 2;
    drive(v, "load_no_use", 1, 1, 0, 0, 0, 1);
    v = idle(); v.mem_read = 1; v.dest = 7; v.rs = 7; v.rt = 7; v.use_rt = 1;
    drive(v, "load_use_rt", 0, 0, 1, 0, 0, 1);
    v = idle();
    drive(v, "idle_a", 1, 1, 0, 0, 0, 2);

    v = idle(); v.mem_read = 1; v.reg_write = 1; v.dest = 3;
    v.br = 1; v.rs = 3; v.use_rs = 1; v.taken = 1;
    drive(v, "ld_br_ex", 0, 0, 1, 0, 0, 2);
    v = idle(); v.exm_rd = 1; v.exm_dest = 3; v.br = 1; v.rs = 3; v.use_rs = 1; v.taken = 1;
    drive(v, "ld_br_mem", 0, 0, 1, 0, 0, 3);
    v = idle(); v.br = 1; v.rs = 3; v.use_rs = 1; v.taken = 1;
    drive(v, "br_flush", 1, 1, 0, 1, 0, 4);
    v = idle();
    drive(v, "idle_b", 1, 1, 0, 0, 0, 4);
    v = idle(); v.reg_write = 1; v.dest = 5; v.br = 1; v.rt = 5; v.use_rt = 1;
    drive(v, "alu_br", 0, 0, 1, 0, 0, 4);
    v = idle(); v.br = 1; v.rt = 5; v.use_rt = 1;
    drive(v, "br_not_taken", 1, 1, 0, 0, 0, 5);
    v = idle(); v.reg_write = 1; v.dest = 5; v.rt = 5; v.use_rt = 1;
    drive(v, "alu_fwd", 1, 1, 0, 0, 0, 5);

    v = idle(); v.mdu_start = 1; v.mdu_use = 1;
    drive(v, "mdu_t", 0, 0, 1, 0, 0, 5);
    v = idle(); v.mdu_use = 1;
    for (int k = 1; k <= MDU; k++) drive(v, "mdu_busy_stall", 0, 0, 1, 0, 1, 5 + k);
    drive(v, "mdu_release", 1, 1, 0, 0, 0, 10);

    v = idle(); v.mdu_start = 1;
    drive(v, "mdu_issue", 1, 1, 0, 0, 0, 10);
    v = idle();
    drive(v, "mdu_run", 1, 1, 0, 0, 1, 10);
    v.mdu_start = 1;
    drive(v, "mdu_reissue", 1, 1, 0, 0, 1, 10);
    v = idle();
    for (int k = 0; k < 4; k++) drive(v, "mdu_reloaded", 1, 1, 0, 0, 1, 10);
    drive(v, "mdu_done", 1, 1, 0, 0, 0, 10);

    v = idle(); v.mdu_start = 1;
    drive(v, "ext_mdu_issue", 1, 1, 0, 0, 0, 10);
    v = idle(); v.ext = 1; v.mem_read = 1; v.dest = 2; v.rs = 2; v.use_rs = 1;
    drive(v, "ext_load_use", 0, 0, 0, 0, 1, 10);
    drive(v, "ext_load_use2", 0, 0, 0, 0, 1, 11);
    v.ext = 0;
    drive(v, "after_ext_lu", 0, 0, 1, 0, 1, 12);
    v = idle();
    drive(v, "ext_mdu_tail", 1, 1, 0, 0, 1, 13);
    v = idle(); v.ext = 1; v.br = 1; v.taken = 1;
    drive(v, "ext_br_taken", 0, 0, 0, 0, 0, 13);
    v = idle();
    drive(v, "idle_e", 1, 1, 0, 0, 0, 14);

    v = idle(); v.mdu_start = 1;
    drive(v, "pre_rst_issue", 1, 1, 0, 0, 0, 14);
    v = idle();
    drive(v, "pre_rst_busy", 1, 1, 0, 0, 1, 14);
    v.rst_n = 0;
    drive(v, "rst_mid_mdu", 0, 0, 1, 0, 0, 0);
    drive(v, "rst_hold", 0, 0, 1, 0, 0, 0);
    v = idle(); v.mdu_use = 1;
    drive(v, "post_rst_no_stall", 1, 1, 0, 0, 0, 0);

    v = idle(); v.ext = 1;
    for (int k = 0; k < 15; k++) drive(v, "sat_count", 0, 0, 0, 0, 0, k);
    for (int k = 0; k < 3; k++) drive(v, "sat_hold", 0, 0, 0, 0, 0, 15);
    v = idle();
    drive(v, "sat_final", 1, 1, 0, 0, 0, 15);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the five-stage MIPS core, sitting beside the ID stage and driving the PC, IF/ID and ID/EX control inputs. It detects load-use hazards, operand hazards for branches resolved in ID, and structural/data hazards against a multi-cycle multiply/divide unit (MDU) tracked by an internal busy counter. It also flushes IF/ID on taken branches, honours an external memory-wait stall, and keeps a saturating count of stall cycles for performance analysis.

## Interface
- AW, 5, register address width
- MDU_CYCLES, 8, MDU latency in cycles after issue (≥1)
- CNT_W, 16, width of stall-cycle counter
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_id_rs, if_id_rt  in  AW each  source registers of the instruction in ID
- if_id_use_rs, if_id_use_rt  in  1 each  instruction in ID actually reads that source
- if_id_branch  in  1  instruction in ID is a branch compared in ID
- if_id_mdu_use  in  1  instruction in ID is mult/div/mfhi/mflo/mthi/mtlo
- branch_taken  in  1  ID-stage branch comparison result
- id_ex_mem_read, id_ex_reg_write  in  1 each  control of instruction in EX
- id_ex_dest  in  AW  destination register of instruction in EX
- id_ex_mdu_start  in  1  instruction in EX issues to the MDU this cycle
- ex_mem_mem_read  in  1  instruction in MEM is a load
- ex_mem_dest  in  AW  destination register of instruction in MEM
- ext_stall  in  1  data/instruction memory wait request
- pc_write  out  1  1 = PC may update
- if_id_write  out  1  1 = IF/ID may update
- id_ex_bubble  out  1  1 = load a NOP into ID/EX
- if_id_flush  out  1  1 = clear IF/ID (taken branch)
- mdu_busy  out  1  MDU counter nonzero
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write = 0

## Operation
- Match rule: m(x) = (x == if_id_rs && if_id_use_rs) || (x == if_id_rt && if_id_use_rt); register 0 never matches.
- load_use = id_ex_mem_read && m(id_ex_dest).
- br_haz = if_id_branch && ((id_ex_reg_write && m(id_ex_dest)) || (ex_mem_mem_read && m(ex_mem_dest))); load-then-branch therefore stalls 2 cycles.
- mdu_haz = if_id_mdu_use && (mdu_busy || id_ex_mdu_start).
- hazard = load_use || br_haz || mdu_haz.
- hazard=1: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0 (branch_taken ignored, operands stale).
- ext_stall=1 (priority over everything): pc_write=0, if_id_write=0, id_ex_bubble=0, if_id_flush=0; pipeline frozen, no bubble.
- Otherwise: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush = if_id_branch && branch_taken.
- MDU counter, width clog2(MDU_CYCLES+1): id_ex_mdu_start loads MDU_CYCLES (reload if already busy, start wins over decrement); else decrement when nonzero. Counter runs regardless of ext_stall. mdu_busy = (counter != 0).
- stall_cycles increments on each edge where pc_write=0; holds at 2^CNT_W−1.

## Timing
- All stall/flush outputs combinational from inputs and current counter; counter and stall_cycles update on rising clk.
- MDU issue in EX at cycle t: an mdu_use instruction in ID stalls cycles t..t+MDU_CYCLES (MDU_CYCLES+1 cycles), proceeds at t+MDU_CYCLES+1.
- Load-use: exactly 1 stall cycle; the following cycle the load is in MEM and forwarding covers it.
- While rst_n=0 (asynchronous): counter=0, stall_cycles=0, mdu_busy=0, pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0. Reset mid-MDU-operation clears busy immediately.
- First edge after rst_n rises: normal evaluation; no residual stall.

## Test plan
- Load $2 in EX, ID reads rs=$2 -> one cycle pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cycles 0->1; next cycle all clear.
- Load $0 in EX, ID reads $0; or load $2 with if_id_use_rs=0 -> no stall.
- Load $3 in EX, ID branch on $3 -> stall 2 cycles (EX then MEM match); branch_taken=1 during stall gives if_id_flush=0; after release if_id_flush=1 one cycle.
- MDU_CYCLES=4, id_ex_mdu_start at t, mflo in ID -> stall cycles t..t+4 (5 cycles), mdu_busy high t+1..t+4; reissue at t+2 reloads counter to 4.
- ext_stall=1 together with load-use -> pc_write=0, id_ex_bubble=0; MDU counter keeps decrementing; stall_cycles increments.
- rst_n low mid-MDU busy (counter=3) -> mdu_busy=0 and stall_cycles=0 immediately; force stall_cycles to max, further stalls hold at 2^CNT_W−1.
